// File: rtl/riscv_branch_resolve.sv
// rtl/riscv_branch_resolve.sv - EX-stage branch resolution, PC redirect and pipeline flush
//
// Purpose:
//   Drives BrUn to the branch comparator, decodes BrEq/BrLT into a taken
//   decision, computes the branch/JAL/JALR target and issues a registered
//   one-cycle redirect followed by a FLUSH_CYCLES-long flush. The front end
//   predicts not-taken, so only taken control transfers redirect.
//   Optional feature macro: RISCV_BR_PERF_CNT_EN (branch/taken counters).
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   br_valid, jal, jalr      control-transfer kind in EX (jalr > jal > br_valid)
//   stall                    EX held by hazard unit, no evaluation
//   funct3                   branch condition select
//   pc_ex, imm, rs1_data     target operands
//   BrEq, BrLT / BrUn        comparator flags in / unsigned select out
//   redirect_valid/pc        registered redirect pulse and held target
//   flush                    squash IF/ID and ID/EX
//   misalign                 pulse for a taken target with bit1 set
//   br_cnt, taken_cnt        performance counters (zero when feature off)

module riscv_branch_resolve #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_valid,
  input  logic                  jal,
  input  logic                  jalr,
  input  logic                  stall,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] pc_ex,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  BrEq,
  input  logic                  BrLT,
  output logic                  BrUn,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  misalign,
  output logic [31:0]           br_cnt,
  output logic [31:0]           taken_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Countdown starts at FLUSH_CYCLES-1 so that flush is high for exactly
  // FLUSH_CYCLES cycles including the cycle the redirect is presented.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                  flush_q, flush_d;
  logic                  misalign_q, misalign_d;

  logic                  br_cond;
  logic                  eval;
  logic                  is_taken;
  logic [DATA_WIDTH-1:0] pc_sum;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    BrUn = (funct3 == 3'b110) || (funct3 == 3'b111);
  end

  // 010/011 are not branch encodings; treat them as never taken.
  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      3'b000:          br_cond = BrEq;
      3'b001:          br_cond = !BrEq;
      3'b100, 3'b110:  br_cond = BrLT;
      3'b101, 3'b111:  br_cond = !BrLT;
      default:         br_cond = 1'b0;
    endcase
  end

  always_comb begin
    eval     = (state_q == ST_IDLE) && !stall;
    is_taken = jalr || jal || (br_valid && br_cond);
    pc_sum   = pc_ex + imm;
    jalr_sum = rs1_data + imm;
    if (jalr) begin
      target = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
    end else begin
      target = pc_sum;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    misalign_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eval && is_taken) begin
          if (target[1]) begin
            // Misaligned target: report it, but keep fetching sequentially.
            misalign_d = 1'b1;
          end else begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = target;
            flush_d          = 1'b1;
            cnt_d            = CNT_INIT;
            state_d          = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Squashed instructions are ignored here, and stall does not
        // pause the countdown.
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 4'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      misalign_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      misalign_q       <= misalign_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign misalign       = misalign_q;

`ifdef RISCV_BR_PERF_CNT_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        br_counted;

  // A conditional branch counts only when it is actually resolved here:
  // not stalled, not squashed, and not overridden by a jump.
  always_comb begin
    br_counted  = eval && br_valid && !jal && !jalr;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if (br_counted) begin
      br_cnt_d = br_cnt_q + 32'd1;
      if (br_cond) begin
        taken_cnt_d = taken_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q    <= 32'd0;
      taken_cnt_q <= 32'd0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
`else
  assign br_cnt    = 32'd0;
  assign taken_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_riscv_branch_resolve.sv
// tb/tb_riscv_branch_resolve.sv - self-checking bench for riscv_branch_resolve

module tb_riscv_branch_resolve;

  localparam int DW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid, jal, jalr, stall;
  logic [2:0]    funct3;
  logic [DW-1:0] pc_ex, imm, rs1_data;
  logic          BrEq, BrLT;
  logic          BrUn;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          flush, misalign;
  logic [31:0]   br_cnt, taken_cnt;

  riscv_branch_resolve #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .jal(jal), .jalr(jalr),
    .stall(stall), .funct3(funct3), .pc_ex(pc_ex), .imm(imm),
    .rs1_data(rs1_data), .BrEq(BrEq), .BrLT(BrLT), .BrUn(BrUn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .misalign(misalign), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a redirect decided in cycle N owns the pipeline until
  // cycle N+FC; nothing is evaluated before cycle N+FC+1.
  longint        mcyc = 0;
  longint        flush_last = -1;
  longint        free_at = 0;
  logic          m_rv = 1'b0, m_fl = 1'b0, m_mis = 1'b0;
  logic [DW-1:0] m_pc = '0;
  logic [31:0]   m_br = '0, m_tk = '0;
  bit            chk_en = 1'b0;

  function automatic logic cond_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return lt;
      3'd7: return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic [DW-1:0] tgt;
    logic          tk;
    if (rst) begin
      m_rv = 0; m_fl = 0; m_mis = 0; m_pc = '0; m_br = '0; m_tk = '0;
      flush_last = -1; free_at = 0;
    end else begin
      m_rv = 0; m_mis = 0;
      if (mcyc >= free_at && !stall && (jalr || jal || br_valid)) begin
        if (jalr) begin
          tgt = (rs1_data + imm) & 32'hFFFF_FFFE; tk = 1;
        end else if (jal) begin
          tgt = pc_ex + imm; tk = 1;
        end else begin
          tgt = pc_ex + imm; tk = cond_taken(funct3, BrEq, BrLT);
`ifdef RISCV_BR_PERF_CNT_EN
          m_br = m_br + 1;
          if (tk) m_tk = m_tk + 1;
`endif
        end
        if (tk) begin
          if (tgt[1]) m_mis = 1;
          else begin
            m_rv = 1; m_pc = tgt;
            flush_last = mcyc + FC;
            free_at = mcyc + FC + 1;
          end
        end
      end
      m_fl = (mcyc + 1 <= flush_last);
    end
    mcyc++;
    chk_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
      chk("redirect_pc", redirect_pc, m_pc);
      chk("flush", {31'd0, flush}, {31'd0, m_fl});
      chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
      chk("br_cnt", br_cnt, m_br);
      chk("taken_cnt", taken_cnt, m_tk);
    end
  end

  // Called at a negedge; applies one cycle of inputs and returns at the
  // following negedge, when that cycle's registered results are visible.
  task automatic drive(input logic r, input logic bv, input logic j, input logic jr,
                       input logic st, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] im, input logic [31:0] r1,
                       input logic eq, input logic lt);
    rst = r; br_valid = bv; jal = j; jalr = jr; stall = st; funct3 = f3;
    pc_ex = pc; imm = im; rs1_data = r1; BrEq = eq; BrLT = lt;
    #1;
    chk("BrUn", {31'd0, BrUn}, {31'd0, (f3 == 3'd6 || f3 == 3'd7)});
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 0);
  endtask

  task automatic br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] im,
                    input logic eq, input logic lt, input logic st);
    drive(0, 1, 0, 0, st, f3, pc, im, 0, eq, lt);
  endtask

  initial begin
    rst = 1; br_valid = 0; jal = 0; jalr = 0; stall = 0; funct3 = 0;
    pc_ex = 0; imm = 0; rs1_data = 0; BrEq = 0; BrLT = 0;
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    chk("reset_rv", {31'd0, redirect_valid}, 32'd0);
    chk("reset_pc", redirect_pc, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_cnt", br_cnt | taken_cnt, 32'd0);

    // BEQ taken
    br(3'd0, 32'h100, 32'h20, 1, 0, 0);
    chk("beq_rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq_pc", redirect_pc, 32'h120);
    chk("beq_flush1", {31'd0, flush}, 32'd1);
    idle(1);
    chk("beq_rv_pulse", {31'd0, redirect_valid}, 32'd0);
    chk("beq_flush2", {31'd0, flush}, 32'd1);
    idle(1);
    chk("beq_flush_end", {31'd0, flush}, 32'd0);
    chk("beq_pc_hold", redirect_pc, 32'h120);

    // funct3 / flag sweep
    for (int f = 0; f < 8; f++) begin
      for (int fl = 0; fl < 4; fl++) begin
        br(3'(f), 32'h1000 + 32'(f * 64), 32'h40, fl[0], fl[1], 0);
        idle(2);
      end
    end
    br(3'd1, 32'h200, 32'h8, 1, 0, 0);
    chk("bne_eq_no_rv", {31'd0, redirect_valid}, 32'd0);
    chk("bne_eq_no_flush", {31'd0, flush}, 32'd0);
    br(3'd7, 32'h300, 32'h10, 0, 0, 0);
    chk("bgeu_rv", {31'd0, redirect_valid}, 32'd1);
    chk("bgeu_pc", redirect_pc, 32'h310);
    idle(2);

    // JALR misaligned, then aligned
    drive(0, 0, 0, 1, 0, 3'd0, 32'h50, 32'h4, 32'h2003, 0, 0);
    chk("jalr_mis", {31'd0, misalign}, 32'd1);
    chk("jalr_mis_no_rv", {31'd0, redirect_valid}, 32'd0);
    chk("jalr_mis_no_flush", {31'd0, flush}, 32'd0);
    drive(0, 0, 0, 1, 0, 3'd0, 32'h50, 32'h5, 32'h2003, 0, 0);
    chk("jalr_rv", {31'd0, redirect_valid}, 32'd1);
    chk("jalr_pc", redirect_pc, 32'h2008);
    chk("jalr_mis_clear", {31'd0, misalign}, 32'd0);
    idle(2);

    // priority: jalr beats jal beats branch
    drive(0, 1, 1, 1, 0, 3'd0, 32'h400, 32'h10, 32'h3000, 1, 0);
    chk("prio_pc", redirect_pc, 32'h3010);
    idle(2);
    drive(0, 1, 1, 0, 0, 3'd1, 32'h400, 32'h2, 32'h0, 1, 0);
    chk("jal_mis", {31'd0, misalign}, 32'd1);
    // wraparound target
    br(3'd0, 32'hFFFF_FFF0, 32'h20, 1, 0, 0);
    chk("wrap_pc", redirect_pc, 32'h10);
    idle(2);

    // back-to-back: squashed branches, then one at N+3
    br(3'd0, 32'h500, 32'h40, 1, 0, 0);
    br(3'd0, 32'h600, 32'h40, 1, 0, 0);
    chk("b2b_no_rv1", {31'd0, redirect_valid}, 32'd0);
    br(3'd0, 32'h700, 32'h40, 1, 0, 0);
    chk("b2b_pc_hold", redirect_pc, 32'h540);
    br(3'd0, 32'h800, 32'h40, 1, 0, 0);
    chk("b2b_n3_rv", {31'd0, redirect_valid}, 32'd1);
    chk("b2b_n3_pc", redirect_pc, 32'h840);
    idle(2);

    // stall holds evaluation; stall inside FLUSH does not pause countdown
    br(3'd0, 32'h900, 32'h4, 1, 0, 1);
    chk("stall_no_rv", {31'd0, redirect_valid}, 32'd0);
    br(3'd0, 32'h900, 32'h4, 1, 0, 0);
    chk("unstall_rv", {31'd0, redirect_valid}, 32'd1);
    chk("unstall_pc", redirect_pc, 32'h904);
    br(3'd0, 32'hA00, 32'h4, 1, 0, 1);
    chk("stall_flush1", {31'd0, flush}, 32'd1);
    br(3'd0, 32'hA00, 32'h4, 1, 0, 1);
    chk("stall_flush_end", {31'd0, flush}, 32'd0);

    // reset mid-FLUSH
    br(3'd0, 32'hB00, 32'h8, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rv", {31'd0, redirect_valid}, 32'd0);
    idle(1);

`ifdef RISCV_BR_PERF_CNT_EN
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.taken_cnt_q;
    m_tk = 32'hFFFF_FFFF;
    br(3'd0, 32'hC00, 32'h8, 1, 0, 0);
    chk("taken_wrap", taken_cnt, 32'h0);
    idle(2);
`else
    chk("cnt_off_br", br_cnt, 32'h0);
    chk("cnt_off_tk", taken_cnt, 32'h0);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rp, ri, rr;
      rp = $urandom; ri = $urandom; rr = $urandom;
      drive(($urandom_range(0, 60) == 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
            rp, ri, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
